// File: rtl/imem_loader.sv
// imem_loader: UART byte-stream loader that writes little-endian 32-bit words into instruction memory and holds the CPU while loading (ports: clk, i_rst active-low sync, i_rx_data/i_rx_valid in; o_din/o_addr/o_wen to imem; o_cpu_hold, o_done, o_err status; optional IMEM_LOADER_TIMEOUT_EN adds an inter-byte timeout)
module imem_loader #(
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int IMEM_DATA_WIDTH = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_COUNT = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NB_BYTE-1:0]         i_rx_data,
  input  logic                       i_rx_valid,
  output logic [IMEM_DATA_WIDTH-1:0] o_din,
  output logic [IMEM_ADDR_WIDTH-1:0] o_addr,
  output logic                       o_wen,
  output logic                       o_cpu_hold,
  output logic                       o_done,
  output logic                       o_err
);
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE, ERR} state_t;
  localparam int CW = NB_COUNT + 1;
  localparam logic [CW-1:0] CAP = CW'(2 ** (IMEM_ADDR_WIDTH - 2));
  localparam int WW = IMEM_DATA_WIDTH - NB_BYTE;
  if (IMEM_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("imem_loader: unsupported configuration");
  end
  state_t state, state_n;
  logic [NB_BYTE-1:0] cnt_lo;
  logic [NB_COUNT-1:0] count;
  logic [CW-1:0] word_idx, n_new;
  logic [1:0] byte_idx;
  logic [WW-1:0] word;
  logic last, to;
  assign n_new = CW'({i_rx_data, cnt_lo});
  assign last = byte_idx == 2'd3 && word_idx + 1'b1 == CW'(count);
  assign o_done = state == DONE;
  assign o_err = state == ERR;
  assign o_cpu_hold = state != IDLE;
`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  always_ff @(posedge clk)
    tmr <= (!i_rst || i_rx_valid || !(state inside {CNT_LO, CNT_HI, DATA})) ? '0 : tmr + 1'b1;
  assign to = tmr == TW'(TIMEOUT_CYCLES);
`else
  assign to = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (i_rx_valid && i_rx_data == NB_BYTE'(8'hA5)) ? CNT_LO : IDLE;
      CNT_LO:  state_n = i_rx_valid ? CNT_HI : to ? ERR : CNT_LO;
      CNT_HI:  state_n = !i_rx_valid ? (to ? ERR : CNT_HI) : n_new == '0 ? DONE : n_new > CAP ? ERR : DATA;
      DATA:    state_n = i_rx_valid ? (last ? DONE : DATA) : to ? ERR : DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt_lo <= '0;
      count <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word <= '0;
      o_din <= '0;
      o_addr <= '0;
      o_wen <= 1'b0;
    end else begin
      state <= state_n;
      o_wen <= 1'b0;
      if (state == CNT_LO && i_rx_valid) cnt_lo <= i_rx_data;
      if (state == CNT_HI && i_rx_valid) begin
        count <= NB_COUNT'({i_rx_data, cnt_lo});
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (state == DATA && i_rx_valid) begin
        byte_idx <= byte_idx + 1'b1;
        word <= {i_rx_data, word[WW-1:NB_BYTE]};
        if (byte_idx == 2'd3) begin
          o_wen <= 1'b1;
          o_din <= {i_rx_data, word};
          o_addr <= {word_idx[IMEM_ADDR_WIDTH-3:0], 2'b00};
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int CAP = 256;
  logic clk = 0, i_rst = 0, i_rx_valid = 0, o_wen, o_cpu_hold, o_done, o_err;
  logic [7:0] i_rx_data = 0;
  logic [31:0] o_din;
  logic [9:0] o_addr;
  int total = 0, bad = 0;
  logic [44:0] exp_q[$];
  logic [9:0] last_addr = 0;
  logic [31:0] last_din = 0;
  logic [31:0] dut_mem[CAP];
  always #5 clk = ~clk;
  imem_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_din(o_din), .o_addr(o_addr), .o_wen(o_wen), .o_cpu_hold(o_cpu_hold),
    .o_done(o_done), .o_err(o_err)
  );
  always @(negedge clk) begin
    logic [44:0] e;
    if (i_rst && (o_wen || o_done || o_err)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL event: unexpected wen=%0b done=%0b err=%0b addr=%h din=%h", o_wen, o_done, o_err, o_addr, o_din);
      end else begin
        e = exp_q.pop_front();
        if ({o_wen, o_done, o_err, o_addr, o_din} !== e) begin
          bad++;
          $display("FAIL event: got wen=%0b done=%0b err=%0b addr=%h din=%h want wen=%0b done=%0b err=%0b addr=%h din=%h",
                   o_wen, o_done, o_err, o_addr, o_din, e[44], e[43], e[42], e[41:32], e[31:0]);
        end
      end
      if (o_wen) dut_mem[o_addr[9:2]] = o_din;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic void push(input bit w, input bit d, input bit e, input logic [9:0] a, input logic [31:0] din);
    exp_q.push_back({w, d, e, a, din});
    if (w) begin
      last_addr = a;
      last_din = din;
    end
  endfunction
  task automatic send(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_valid = 1;
    @(negedge clk);
    i_rx_valid = 0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic frame_q(input int n, input logic [31:0] ws[$], input int gmax);
    logic [31:0] w;
    send(8'hA5, 0);
    chk("hold_after_a5", o_cpu_hold, 1);
    send(n[7:0], $urandom_range(gmax, 0));
    if (n == 0) push(0, 1, 0, last_addr, last_din);
    else if (n > CAP) push(0, 0, 1, last_addr, last_din);
    send(n[15:8], 0);
    for (int i = 0; i < ws.size(); i++) begin
      w = ws[i];
      for (int k = 0; k < 4; k++) begin
        if (k == 3) push(1, i == n - 1, 0, 10'(i * 4), w);
        send(w[8*k+:8], (k == 3 && i == n - 1) ? 0 : $urandom_range(gmax, 0));
      end
    end
    chk("end_pulse", {o_done, o_err, o_cpu_hold}, {n <= CAP, n > CAP, 1'b1});
    @(negedge clk);
    chk("hold_release", o_cpu_hold, 0);
  endtask
  task automatic frame(input int n, input int gmax);
    logic [31:0] ws[$];
    if (n <= CAP) for (int i = 0; i < n; i++) ws.push_back($urandom);
    frame_q(n, ws, gmax);
  endtask
  initial begin
    logic [31:0] w0, w1, dq[$];
    repeat (2) @(negedge clk);
    chk("reset_outputs", {o_din, o_addr, o_wen, o_cpu_hold, o_done, o_err}, 0);
    i_rst = 1;
    @(negedge clk);
    dq = '{32'h00100513, 32'h00200593};
    frame_q(2, dq, 0);
    chk("dmem0", dut_mem[0], 32'h00100513);
    chk("dmem1", dut_mem[1], 32'h00200593);
    frame(0, 0);
    frame(257, 0);
    frame(65535, 2);
    frame(256, 0);
    chk("dmem_last", dut_mem[255], last_din);
    chk("last_addr", last_addr, 10'h3FC);
    send(8'h00, 1);
    send(8'hFF, 0);
    send(8'h5A, 2);
    chk("noise_no_hold", o_cpu_hold, 0);
    for (int r = 0; r < 6; r++) frame($urandom_range(8, 1), r % 2 == 0 ? 0 : 3);
    w0 = $urandom;
    w1 = $urandom;
    send(8'hA5, 0);
    send(8'h03, 1);
    send(8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push(1, 0, 0, 10'h000, w0);
      send(w0[8*k+:8], 0);
    end
    send(w1[7:0], 1);
    send(w1[15:8], 0);
    i_rst = 0;
    @(negedge clk);
    chk("midload_reset", {o_din, o_addr, o_wen, o_cpu_hold, o_done, o_err}, 0);
    i_rst = 1;
    last_addr = 0;
    last_din = 0;
    chk("mem0_kept", dut_mem[0], w0);
    frame(3, 1);
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h00, 0);
`ifdef IMEM_LOADER_TIMEOUT_EN
    push(0, 0, 1, last_addr, last_din);
    repeat (60) @(negedge clk);
    chk("timeout_idle", o_cpu_hold, 0);
`else
    repeat (60) @(negedge clk);
    chk("stall_hold", o_cpu_hold, 1);
    w0 = $urandom;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push(1, 1, 0, 10'h000, w0);
      send(w0[8*k+:8], 0);
    end
    chk("stall_done", {o_done, o_cpu_hold}, 2'b11);
`endif
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that sits upstream of the instruction memory in `cpu_core`. It takes received UART bytes, assembles little-endian 32-bit instruction words and drives the instruction memory write port. While a load is in progress it holds the CPU pipeline. It is the source of the currently unconnected `i_din`/`i_wen` memory inputs and of the core's hold signal.

## Interface
- `IMEM_ADDR_WIDTH`, 10: instruction memory byte-address width. Capacity is 2^IMEM_ADDR_WIDTH/4 words.
- `IMEM_DATA_WIDTH`, 32: instruction word width. Only 32 is supported.
- `NB_BYTE`, 8: UART byte width.
- `NB_COUNT`, 16: width of the word-count field.
- `TIMEOUT_CYCLES`, 1000000: inter-byte timeout. Used only with `IMEM_LOADER_TIMEOUT_EN`.
- `clk`  in  1  clock. Single clock domain; everything is on the rising edge.
- `i_rst`  in  1  reset. Synchronous, active-low.
- `i_rx_data`  in  8  received byte.
- `i_rx_valid`  in  1  one-cycle strobe: `i_rx_data` is valid.
- `o_din`  out  32  write data to the instruction memory.
- `o_addr`  out  IMEM_ADDR_WIDTH  byte address to the instruction memory. Always word aligned, with bits [1:0] = 0.
- `o_wen`  out  1  instruction memory write enable, one-cycle pulse.
- `o_cpu_hold`  out  1  high while a load is active. Drives the PC/IF-ID enables low and holds the core.
- `o_done`  out  1  one-cycle pulse: load completed.
- `o_err`  out  1  one-cycle pulse: load aborted.

## Operation
- Frame format: command byte 0xA5, then count_lo, then count_hi (N = 16-bit word count), then N×4 data bytes. Data bytes are little-endian: the first byte goes to [7:0].
- States:
  - IDLE: a byte equal to 0xA5 moves to CNT_LO. Any other byte is ignored.
  - CNT_LO: latch count[7:0], move to CNT_HI.
  - CNT_HI: latch count[15:8], then:
    - N = 0 → DONE.
    - N > capacity → ERR.
    - otherwise → DATA, with word index = 0 and byte index = 0.
  - DATA: shift each accepted byte into the word register.
    - On the 4th byte, register the word and the address = word index × 4, and issue the write.
    - Increment the word index and clear the byte index.
    - After the write of word N-1 → DONE.
  - DONE: lasts one cycle, then → IDLE.
  - ERR: lasts one cycle, then → IDLE.
- Outputs per state:
  - `o_done` = 1 only in DONE.
  - `o_err` = 1 only in ERR.
  - `o_cpu_hold` = 1 in every state except IDLE.
- Bytes received in DONE or ERR are ignored.
- The word index is NB_COUNT+1 bits wide, so no wrap is possible inside a legal load. The last legal address is capacity×4−4 (0x3FC by default).
- Reset (`i_rst` = 0 at an edge), including mid-load:
  - state → IDLE and the byte/word indices clear;
  - all outputs → 0 (`o_din` = 0, `o_addr` = 0, `o_wen` = 0, `o_cpu_hold` = 0, `o_done` = 0, `o_err` = 0);
  - the partial word is discarded;
  - memory words already written are left untouched.

## Timing
- Counting edges from the edge t at which a byte with `i_rx_valid` = 1 is accepted:
  - 4th byte of a word accepted at edge t → `o_wen` = 1 with stable `o_din`/`o_addr` during cycle t+1, for exactly one cycle.
  - Last data byte accepted at t → `o_wen` and `o_done` both high during cycle t+1; `o_cpu_hold` drops at cycle t+2.
  - N = 0 (count_hi accepted at t) → `o_done` during t+1, no write.
  - Over-capacity count (count_hi at t) → `o_err` during t+1, no write.
  - 0xA5 accepted at t → `o_cpu_hold` = 1 from cycle t+1.
- Back-to-back `i_rx_valid` on consecutive cycles is accepted in all states. No bytes are dropped inside a frame.
- `o_din` and `o_addr` hold their last value when `o_wen` = 0.

## Configuration
- Macro: `IMEM_LOADER_TIMEOUT_EN`.
- Defined:
  - a counter runs in CNT_LO, CNT_HI and DATA;
  - it clears on every accepted byte and on entry to CNT_LO;
  - when it reaches TIMEOUT_CYCLES with no byte → ERR (`o_err` pulse), then IDLE, with the partial word discarded.
- Not defined: no counter is present and the loader waits indefinitely for the next byte.

## Test plan
- Two-word load: send A5 02 00 13 05 10 00 93 05 20 00.
  - Expect `o_wen` pulses with addr 0x000 / din 0x00100513, then addr 0x004 / din 0x00200593.
  - `o_done` coincides with the second `o_wen`.
  - `o_cpu_hold` is high from the cycle after A5 to the cycle after `o_done`.
- Zero count: send A5 00 00 → `o_done` on the cycle after the third byte, no `o_wen`, hold lasts 3 cycles.
- Capacity limits:
  - A5 01 01 (257 words) → `o_err` pulse, no writes, back in IDLE.
  - A5 00 01 with 1024 bytes → 256 writes, last at addr 0x3FC, then `o_done`.
- Reset mid-load: assert `i_rst` = 0 after the 6th data byte of a 3-word load.
  - Expect all outputs 0 the next cycle; word 0 remains in memory.
  - A new A5 frame afterwards loads correctly from addr 0x000.
- Idle noise and back-to-back bytes:
  - Bytes 00 FF 5A in IDLE → no hold, no writes.
  - A full frame with `i_rx_valid` high on consecutive cycles → correct words.
- Timeout (macro defined, TIMEOUT_CYCLES = 50):
  - Stall 50 cycles after count_hi → `o_err` pulse, then IDLE.
  - Without the macro, the same stall leaves `o_cpu_hold` high indefinitely.
